// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with occupancy count and
// programmable almost-full / almost-empty thresholds.
// Optional feature macro: SYNC_FIFO_ERR_EN adds clr_err/overflow/underflow
// (sticky error flags for writes while full and reads while empty).
module sync_fifo_param #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 32,
   parameter int AF_THRESH = 28,
   parameter int AE_THRESH = 4,
   localparam int ADDR_W   = $clog2(DEPTH),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_op,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CNT_W-1:0]  count
`ifdef SYNC_FIFO_ERR_EN
   ,
   input  logic              clr_err,
   output logic              overflow,
   output logic              underflow
`endif
);

   // Last valid address; pointers wrap here so DEPTH need not be a power of two.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              wr_acc;
   logic              rd_acc;

   // Accept decisions use pre-edge flags, so a read of an empty FIFO never
   // sees the word being written in the same cycle.
   always_comb begin
      wr_acc = wr_en & ~full;
      rd_acc = rd_en & ~empty;
   end

   // Status flags are pure decodes of the registered count.
   always_comb begin
      full         = (count == CNT_W'(DEPTH));
      empty        = (count == '0);
      almost_full  = (count >= CNT_W'(AF_THRESH));
      almost_empty = (count <= CNT_W'(AE_THRESH));
   end

   // Storage array: written on accepted writes, intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= data_in;
   end

   // Pointers, occupancy and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         data_op <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
         if (rd_acc) begin
            rd_ptr  <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_W'(1);
            data_op <= mem[rd_ptr];
         end
         if (wr_acc && !rd_acc)
            count <= count + CNT_W'(1);
         else if (rd_acc && !wr_acc)
            count <= count - CNT_W'(1);
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   // Sticky error flags; a new set event in the clear cycle keeps the flag high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  & ~clr_err) | (wr_en & full);
         underflow <= (underflow & ~clr_err) | (rd_en & empty);
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=32, DEPTH=32, AF=28, AE=4).
// Error-flag checks are compiled in when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] data_in;
   logic        rd_en;
   logic [31:0] data_op;
   logic        full, empty, almost_full, almost_empty;
   logic [5:0]  count;
`ifdef SYNC_FIFO_ERR_EN
   logic        clr_err;
   logic        overflow, underflow;
`endif

   int checks = 0;
   int errors = 0;

   sync_fifo_param #(
      .DATA_W(32), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_op      (data_op),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .clr_err      (clr_err),
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive request, step past the edge, return to idle.
   task automatic cyc(input logic w, input logic [31:0] d, input logic r);
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
`ifdef SYNC_FIFO_ERR_EN
      clr_err = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_data", 64'(data_op), 64'd0);
      check("rst_ae", 64'(almost_empty), 64'd1);
      check("rst_af", 64'(almost_full), 64'd0);
      rst = 1'b0;

      // 1: async reset mid-traffic with count=10
      for (int i = 0; i < 11; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
      cyc(1'b0, '0, 1'b1);
      check("t1_pre_count", 64'(count), 64'd10);
      check("t1_pre_data", 64'(data_op), 64'h100);
      rst = 1'b1;
      #2;
      check("t1_async_empty", 64'(empty), 64'd1);
      check("t1_async_count", 64'(count), 64'd0);
      check("t1_async_data", 64'(data_op), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 2: fill, overfill, drain
      for (int i = 0; i < 32; i++) begin
         cyc(1'b1, 32'(i), 1'b0);
         check("t2_fill_count", 64'(count), 64'(i + 1));
         check("t2_fill_af", 64'(almost_full), 64'((i + 1) >= 28));
         check("t2_fill_full", 64'(full), 64'((i + 1) == 32));
      end
      cyc(1'b1, 32'h999, 1'b0);
      check("t2_drop_count", 64'(count), 64'd32);
      check("t2_drop_full", 64'(full), 64'd1);
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("t2_drain_data", 64'(data_op), 64'(i));
         check("t2_drain_count", 64'(count), 64'(31 - i));
         check("t2_drain_ae", 64'(almost_empty), 64'((31 - i) <= 4));
         check("t2_drain_empty", 64'(empty), 64'(i == 31));
      end

      // 3: steady state at count=5 across several pointer wraps
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'd1000 + 32'(i), 1'b0);
      for (int j = 0; j < 100; j++) begin
         cyc(1'b1, 32'd1005 + 32'(j), 1'b1);
         check("t3_wrap_data", 64'(data_op), 64'(1000 + j));
         check("t3_wrap_count", 64'(count), 64'd5);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("t3_tail_data", 64'(data_op), 64'(1100 + i));
      end
      check("t3_empty", 64'(empty), 64'd1);

      // 4: full with simultaneous read and write
      for (int i = 0; i < 32; i++) cyc(1'b1, 32'd2000 + 32'(i), 1'b0);
      check("t4_full", 64'(full), 64'd1);
      cyc(1'b1, 32'hDEAD, 1'b1);
      check("t4_count", 64'(count), 64'd31);
      check("t4_data", 64'(data_op), 64'd2000);
      check("t4_not_full", 64'(full), 64'd0);
      for (int i = 1; i < 32; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("t4_drain_data", 64'(data_op), 64'(2000 + i));
      end
      check("t4_empty", 64'(empty), 64'd1);

      // 5: empty with simultaneous read and write
      cyc(1'b1, 32'hBEEF, 1'b1);
      check("t5_count", 64'(count), 64'd1);
      check("t5_data_held", 64'(data_op), 64'd2031);
      cyc(1'b0, '0, 1'b1);
      check("t5_read", 64'(data_op), 64'hBEEF);
      check("t5_empty", 64'(empty), 64'd1);

`ifdef SYNC_FIFO_ERR_EN
      // 6: sticky error flags
      clr_err = 1'b1;
      cyc(1'b0, '0, 1'b0);
      clr_err = 1'b0;
      check("t6_clr_ovf", 64'(overflow), 64'd0);
      check("t6_clr_udf", 64'(underflow), 64'd0);
      cyc(1'b0, '0, 1'b1);
      check("t6_udf_set", 64'(underflow), 64'd1);
      cyc(1'b0, '0, 1'b0);
      check("t6_udf_sticky", 64'(underflow), 64'd1);
      clr_err = 1'b1;
      cyc(1'b0, '0, 1'b0);
      clr_err = 1'b0;
      check("t6_udf_clr", 64'(underflow), 64'd0);
      for (int i = 0; i < 32; i++) cyc(1'b1, 32'(i), 1'b0);
      check("t6_ovf_quiet", 64'(overflow), 64'd0);
      clr_err = 1'b1;
      cyc(1'b1, 32'h55, 1'b0);
      clr_err = 1'b0;
      check("t6_ovf_wins", 64'(overflow), 64'd1);
      check("t6_ovf_count", 64'(count), 64'd32);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
